// File: rtl/bsg_manycore_scratch_responder_pkg.sv
// Packet/link types, responder FSM states and shared AMO/load helpers for the
// manycore scratchpad responder.
package bsg_manycore_scratch_responder_pkg;

  localparam int mc_addr_width_gp    = 28;
  localparam int mc_data_width_gp    = 32;
  localparam int mc_x_cord_width_gp  = 7;
  localparam int mc_y_cord_width_gp  = 7;
  localparam int mc_reg_id_width_gp  = 5;

  typedef enum logic [3:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_amoswap = 4'd2,
    e_remote_amoadd  = 4'd3,
    e_remote_amoor   = 4'd4,
    e_remote_amoxor  = 4'd5,
    e_remote_amoand  = 4'd6,
    e_cache_op       = 4'd7
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } bsg_manycore_return_packet_type_e;

  typedef enum logic [1:0] {e_idle, e_access, e_amo_wr, e_resp} bsg_manycore_scratch_resp_state_e;

  typedef enum logic [1:0] {e_alu_swap, e_alu_add, e_alu_or} bsg_manycore_amo_alu_e;

  // Carried in payload[4:0] of a remote load.
  typedef struct packed {
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } bsg_manycore_load_info_s;

  typedef struct packed {
    logic [mc_addr_width_gp-1:0]   addr;
    logic [3:0]                    op;
    logic [3:0]                    op_ex;
    logic [mc_reg_id_width_gp-1:0] reg_id;
    logic [mc_data_width_gp-1:0]   payload;
    logic [mc_y_cord_width_gp-1:0] src_y_cord;
    logic [mc_x_cord_width_gp-1:0] src_x_cord;
    logic [mc_y_cord_width_gp-1:0] y_cord;
    logic [mc_x_cord_width_gp-1:0] x_cord;
  } bsg_manycore_packet_s;

  typedef struct packed {
    bsg_manycore_return_packet_type_e pkt_type;
    logic [mc_data_width_gp-1:0]      data;
    logic [mc_reg_id_width_gp-1:0]    reg_id;
    logic [mc_y_cord_width_gp-1:0]    y_cord;
    logic [mc_x_cord_width_gp-1:0]    x_cord;
  } bsg_manycore_return_packet_s;

  typedef struct packed {
    logic                 v;
    bsg_manycore_packet_s data;
    logic                 ready_and_rev;
  } bsg_manycore_fwd_link_sif_s;

  typedef struct packed {
    logic                        v;
    bsg_manycore_return_packet_s data;
    logic                        ready_and_rev;
  } bsg_manycore_rev_link_sif_s;

  typedef struct packed {
    bsg_manycore_fwd_link_sif_s fwd;
    bsg_manycore_rev_link_sif_s rev;
  } bsg_manycore_link_sif_s;

  localparam int bsg_manycore_link_sif_width_gp = $bits(bsg_manycore_link_sif_s);

  function automatic bsg_manycore_amo_alu_e amo_alu_decode(input logic [3:0] op);
    bsg_manycore_amo_alu_e alu;
    case (op)
      e_remote_amoadd: alu = e_alu_add;
      e_remote_amoor:  alu = e_alu_or;
      default:         alu = e_alu_swap;
    endcase
    return alu;
  endfunction

  function automatic logic [mc_data_width_gp-1:0] amo_alu(
    input bsg_manycore_amo_alu_e       alu,
    input logic [mc_data_width_gp-1:0] old_val,
    input logic [mc_data_width_gp-1:0] operand
  );
    logic [mc_data_width_gp-1:0] res;
    case (alu)
      e_alu_add: res = old_val + operand;
      e_alu_or:  res = old_val | operand;
      default:   res = operand;
    endcase
    return res;
  endfunction

  // Same extend/shift as the vanilla core load packer; byte wins over half.
  function automatic logic [mc_data_width_gp-1:0] load_pack(
    input logic [mc_data_width_gp-1:0] word,
    input bsg_manycore_load_info_s     info
  );
    logic [7:0]                  b;
    logic [15:0]                 h;
    logic [mc_data_width_gp-1:0] res;
    b = word[{info.part_sel, 3'b000} +: 8];
    h = word[{info.part_sel[1], 4'b0000} +: 16];
    if (info.is_byte_op)     res = {{24{~info.is_unsigned_op & b[7]}}, b};
    else if (info.is_hex_op) res = {{16{~info.is_unsigned_op & h[15]}}, h};
    else                     res = word;
    return res;
  endfunction

endpackage

// File: rtl/bsg_manycore_scratch_responder_mem.sv
// Single-port synchronous scratchpad with per-byte write enables; the read
// port is registered and only updates on a read.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p        = 1024,
  parameter int data_width_p = 32,
  parameter int addr_width_p = $clog2(els_p)
) (
  input  logic                      clk_i,
  input  logic                      v_i,
  input  logic                      w_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [data_width_p/8-1:0] write_mask_i,
  output logic [data_width_p-1:0]   data_o
);
  localparam int bytes_lp = data_width_p / 8;

  logic [bytes_lp-1:0][7:0]   rd_bytes;
  logic [data_width_p-1:0]    data_q, data_d;

  for (genvar b = 0; b < bytes_lp; b++) begin : g_byte
    logic [7:0] bank [els_p];
    always_ff @(posedge clk_i)
      if (v_i & w_i & write_mask_i[b]) bank[addr_i] <= data_i[8*b +: 8];
    assign rd_bytes[b] = bank[addr_i];
  end

  assign data_d = (v_i & ~w_i) ? rd_bytes : data_q;

  always_ff @(posedge clk_i) data_q <= data_d;

  assign data_o = data_q;
endmodule

// File: rtl/bsg_manycore_scratch_responder.sv
// Manycore endpoint serving remote loads, masked stores and word AMOs from a
// local scratchpad; one reverse packet per forward packet, one in flight.
module bsg_manycore_scratch_responder
  import bsg_manycore_scratch_responder_pkg::*;
#(
  parameter int addr_width_p   = mc_addr_width_gp,
  parameter int data_width_p   = mc_data_width_gp,
  parameter int x_cord_width_p = mc_x_cord_width_gp,
  parameter int y_cord_width_p = mc_y_cord_width_gp,
  parameter int els_p          = 1024
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [bsg_manycore_link_sif_width_gp-1:0] link_sif_i,
  output logic [bsg_manycore_link_sif_width_gp-1:0] link_sif_o,
  input  logic [x_cord_width_p-1:0]                 global_x_i,
  input  logic [y_cord_width_p-1:0]                 global_y_i,
  output logic                                      err_o
);
  localparam int lg_els_lp = $clog2(els_p);

  bsg_manycore_link_sif_s            link_in, link_out;
  bsg_manycore_packet_s              req_q, req_d;
  bsg_manycore_return_packet_s       rsp;
  bsg_manycore_scratch_resp_state_e  state_q, state_d;
  bsg_manycore_load_info_s           load_info;
  logic                              err_q, err_d, in_reset_q, in_reset_d;
  logic                              fwd_ready, fwd_hs;
  logic [addr_width_p-1:0]           req_addr;
  logic                              in_range, is_load, is_store, is_amo, req_ok;
  logic                              mem_req, mem_v, mem_w;
  logic [data_width_p/8-1:0]         mem_mask;
  logic [data_width_p-1:0]           mem_wdata, mem_rdata;
  logic                              unused_sig;

  assign link_in    = link_sif_i;
  assign in_reset_d = reset_i;

  // Ready is held low for the first cycle after reset drops.
  assign fwd_ready = (state_q == e_idle) & ~in_reset_q;
  assign fwd_hs    = link_in.fwd.v & fwd_ready;

  assign req_addr  = req_q.addr;
  assign in_range  = req_addr < addr_width_p'(els_p);
  assign is_load   = req_q.op == e_remote_load;
  assign is_store  = req_q.op == e_remote_store;
  assign is_amo    = (req_q.op == e_remote_amoswap) | (req_q.op == e_remote_amoadd)
                   | (req_q.op == e_remote_amoor);
  assign req_ok    = in_range & (is_load | is_store | is_amo);
  assign load_info = req_q.payload[$bits(bsg_manycore_load_info_s)-1:0];

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    err_d     = err_q;
    mem_req   = 1'b0;
    mem_w     = 1'b0;
    mem_mask  = '0;
    mem_wdata = '0;
    unique case (state_q)
      e_idle: if (fwd_hs) begin
        req_d   = link_in.fwd.data;
        state_d = e_access;
      end
      e_access: begin
        state_d = e_resp;
        if (!req_ok) err_d = 1'b1;
        else if (is_store) begin
          mem_req   = 1'b1;
          mem_w     = 1'b1;
          mem_mask  = req_q.op_ex;
          mem_wdata = req_q.payload;
        end else begin
          mem_req = 1'b1;
          if (is_amo) state_d = e_amo_wr;
        end
      end
      e_amo_wr: begin
        mem_req   = 1'b1;
        mem_w     = 1'b1;
        mem_mask  = '1;
        mem_wdata = amo_alu(amo_alu_decode(req_q.op), mem_rdata, req_q.payload);
        state_d   = e_resp;
      end
      e_resp: if (link_in.rev.ready_and_rev) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // An access racing a reset is dropped along with its request.
  assign mem_v = mem_req & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
    req_q      <= req_d;
    in_reset_q <= in_reset_d;
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p       (els_p),
    .data_width_p(data_width_p)
  ) scratch (
    .clk_i       (clk_i),
    .v_i         (mem_v),
    .w_i         (mem_w),
    .addr_i      (req_q.addr[lg_els_lp-1:0]),
    .data_i      (mem_wdata),
    .write_mask_i(mem_mask),
    .data_o      (mem_rdata)
  );

  // Read data stays put through e_resp since the memory is idle there.
  always_comb begin
    rsp          = '0;
    rsp.pkt_type = is_store ? e_return_credit : e_return_int_wb;
    rsp.reg_id   = req_q.reg_id;
    rsp.y_cord   = req_q.src_y_cord;
    rsp.x_cord   = req_q.src_x_cord;
    if (req_ok & is_amo)       rsp.data = mem_rdata;
    else if (req_ok & is_load) rsp.data = load_pack(mem_rdata, load_info);
  end

  always_comb begin
    link_out                   = '0;
    link_out.fwd.ready_and_rev = fwd_ready;
    link_out.rev.v             = state_q == e_resp;
    link_out.rev.data          = rsp;
  end

  assign link_sif_o = link_out;
  assign err_o      = err_q;

  assign unused_sig = ^{global_x_i, global_y_i, req_q.y_cord, req_q.x_cord,
                        link_in.fwd.ready_and_rev, link_in.rev.v, link_in.rev.data};
endmodule

// File: tb/tb_bsg_manycore_scratch_responder.sv
// Randomized bench for the scratch responder against a word-array model.
module tb_bsg_manycore_scratch_responder;
  import bsg_manycore_scratch_responder_pkg::*;

  localparam int ELS = 1024;

  logic clk = 1'b0;
  logic reset_i;
  logic err;
  logic [bsg_manycore_link_sif_width_gp-1:0] link_in, link_out;
  logic [mc_x_cord_width_gp-1:0] gx;
  logic [mc_y_cord_width_gp-1:0] gy;
  bsg_manycore_link_sif_s lin, lout;

  assign link_in = lin;
  assign lout    = link_out;

  bsg_manycore_scratch_responder #(.els_p(ELS)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .link_sif_i(link_in),
    .link_sif_o(link_out),
    .global_x_i(gx),
    .global_y_i(gy),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int unsigned mem_m [int];
  bit err_m = 0;

  function automatic int unsigned load_ref(input int unsigned w, input logic [4:0] li);
    int unsigned v;
    if (li[3]) begin
      v = (w >> (8 * li[1:0])) & 32'hFF;
      if (!li[4] && v[7]) v = v | 32'hFFFFFF00;
    end else if (li[2]) begin
      v = (w >> (16 * li[1])) & 32'hFFFF;
      if (!li[4] && v[15]) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  function automatic bsg_manycore_return_packet_s model(input bsg_manycore_packet_s p, output int lat);
    bsg_manycore_return_packet_s r;
    int unsigned old, nw, msk;
    bit ok, amo;
    amo = (p.op == e_remote_amoswap) || (p.op == e_remote_amoadd) || (p.op == e_remote_amoor);
    ok  = (p.addr < ELS) && (amo || p.op == e_remote_load || p.op == e_remote_store);
    r.reg_id   = p.reg_id;
    r.y_cord   = p.src_y_cord;
    r.x_cord   = p.src_x_cord;
    r.pkt_type = (p.op == e_remote_store) ? e_return_credit : e_return_int_wb;
    r.data     = 0;
    lat = (ok && amo) ? 3 : 2;
    if (!ok) err_m = 1;
    else begin
      old = mem_m.exists(int'(p.addr)) ? mem_m[int'(p.addr)] : 0;
      if (p.op == e_remote_store) begin
        nw = old;
        for (int i = 0; i < 4; i++) if (p.op_ex[i]) begin
          msk = 32'hFF << (8 * i);
          nw = (nw & ~msk) | (p.payload & msk);
        end
        mem_m[int'(p.addr)] = nw;
      end else if (p.op == e_remote_load) begin
        r.data = load_ref(old, p.payload[4:0]);
      end else begin
        r.data = old;
        if (p.op == e_remote_amoswap)     mem_m[int'(p.addr)] = p.payload;
        else if (p.op == e_remote_amoadd) mem_m[int'(p.addr)] = old + p.payload;
        else                              mem_m[int'(p.addr)] = old | p.payload;
      end
    end
    return r;
  endfunction

  function automatic bsg_manycore_packet_s mk(input logic [3:0] op, input int unsigned addr,
                                              input logic [3:0] op_ex, input logic [31:0] payload);
    bsg_manycore_packet_s p;
    p.addr       = addr[27:0];
    p.op         = op;
    p.op_ex      = op_ex;
    p.payload    = payload;
    p.reg_id     = 5'($urandom);
    p.src_y_cord = 7'($urandom);
    p.src_x_cord = 7'($urandom);
    p.y_cord     = 7'($urandom);
    p.x_cord     = 7'($urandom);
    return p;
  endfunction

  // One request: immediate accept, checked latency, optional rev stall.
  task automatic do_txn(input bsg_manycore_packet_s p, input int stall, input string name);
    bsg_manycore_return_packet_s exp, got;
    int lat, k;
    exp = model(p, lat);
    @(negedge clk);
    lin.fwd.v = 1'b1;
    lin.fwd.data = p;
    lin.rev.ready_and_rev = (stall == 0);
    checks++;
    if (lout.fwd.ready_and_rev !== 1'b1) begin
      errors++;
      $display("FAIL %s fwd_ready: got %b required 1", name, lout.fwd.ready_and_rev);
    end
    k = 0;
    while (lout.fwd.ready_and_rev !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    lin.fwd.v = 1'b0;
    k = 1;
    while (lout.rev.v !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k != lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, k, lat);
    end
    got = lout.rev.data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (lout.rev.v !== 1'b1 || lout.rev.data !== got || lout.fwd.ready_and_rev !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_hold: v=%b data=%h fwd_ready=%b required v=1 data=%h fwd_ready=0",
                 name, lout.rev.v, lout.rev.data.data, lout.fwd.ready_and_rev, got.data);
      end
    end
    lin.rev.ready_and_rev = 1'b1;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s resp: got type=%0d data=%h reg=%0d y=%0d x=%0d required type=%0d data=%h reg=%0d y=%0d x=%0d",
               name, got.pkt_type, got.data, got.reg_id, got.y_cord, got.x_cord,
               exp.pkt_type, exp.data, exp.reg_id, exp.y_cord, exp.x_cord);
    end
    checks++;
    if (err !== err_m) begin
      errors++;
      $display("FAIL %s err_o: got %b required %b", name, err, err_m);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (lout.fwd.ready_and_rev !== 1'b0 || lout.rev.v !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: fwd_ready=%b rev_v=%b err=%b required 0 0 0",
               lout.fwd.ready_and_rev, lout.rev.v, err);
    end
    reset_i = 1'b0;
    #1;
    checks++;
    if (lout.fwd.ready_and_rev !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_same_cycle: fwd_ready=%b required 0", lout.fwd.ready_and_rev);
    end
    @(negedge clk);
    checks++;
    if (lout.fwd.ready_and_rev !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_next_cycle: fwd_ready=%b required 1", lout.fwd.ready_and_rev);
    end
  endtask

  task automatic test_prefill();
    for (int a = 0; a < 16; a++) do_txn(mk(e_remote_store, a, 4'hF, $urandom), 0, "prefill");
  endtask

  task automatic test_store_load();
    do_txn(mk(e_remote_store, 5, 4'hF, 32'hDEADBEEF), 0, "store_full");
    do_txn(mk(e_remote_load, 5, 4'h0, 32'h0), 0, "load_word");
    do_txn(mk(e_remote_store, 5, 4'b0010, 32'h0000AB00), 0, "store_mask");
    do_txn(mk(e_remote_load, 5, 4'h0, 32'h0000000A), 0, "load_byte_signed");
    do_txn(mk(e_remote_load, 5, 4'h0, 32'h00000016), 1, "load_hex_unsigned");
  endtask

  task automatic test_amo();
    do_txn(mk(e_remote_store, 20, 4'hF, 32'hFFFFFFFF), 0, "amo_init");
    do_txn(mk(e_remote_amoadd, 20, 4'h0, 32'd1), 0, "amoadd");
    do_txn(mk(e_remote_amoswap, 20, 4'h0, 32'd7), 2, "amoswap");
    do_txn(mk(e_remote_amoor, 20, 4'h0, 32'd8), 0, "amoor");
    do_txn(mk(e_remote_load, 20, 4'h0, 32'h0), 0, "amo_readback");
  endtask

  task automatic test_err();
    do_txn(mk(e_remote_load, ELS, 4'h0, 32'h0), 0, "load_oob");
    do_txn(mk(e_remote_load, 5, 4'h0, 32'h0), 0, "load_after_oob");
    do_txn(mk(e_remote_store, ELS + 1, 4'hF, 32'h12345678), 0, "store_oob");
    do_txn(mk(e_remote_amoadd, ELS + 2, 4'h0, 32'h5), 0, "amo_oob");
    do_txn(mk(e_remote_amoxor, 3, 4'h0, 32'h5), 0, "bad_op");
    do_txn(mk(e_remote_load, 1, 4'h0, 32'h0), 0, "alias_unchanged");
    do_txn(mk(e_remote_load, 2, 4'h0, 32'h0), 0, "amo_alias_unchanged");
  endtask

  task automatic test_random();
    int r, st;
    logic [3:0] op;
    int unsigned addr;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 15);
      op = (r < 4) ? e_remote_load : (r < 8) ? e_remote_store : (r < 10) ? e_remote_amoswap :
           (r < 12) ? e_remote_amoadd : (r < 14) ? e_remote_amoor : 4'($urandom_range(5, 15));
      addr = ($urandom_range(0, 9) == 0) ? ELS + $urandom_range(0, 5000) : $urandom_range(0, 15);
      st = $urandom_range(0, 3);
      do_txn(mk(op, addr, 4'($urandom), $urandom), st, "random");
    end
  endtask

  task automatic test_backpressure();
    bsg_manycore_packet_s        q [4];
    bsg_manycore_return_packet_s e [4];
    int acc [4];
    int hs [4];
    int lat;
    for (int i = 0; i < 4; i++) begin
      q[i] = mk(e_remote_load, i * 3, 4'h0, $urandom & 32'h1F);
      e[i] = model(q[i], lat);
    end
    @(negedge clk);
    fork
      begin
        int kd;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          lin.fwd.v = 1'b1;
          lin.fwd.data = q[i];
          kd = 0;
          while (lout.fwd.ready_and_rev !== 1'b1 && kd < 200) begin @(negedge clk); kd++; end
          acc[i] = cyc;
        end
        @(negedge clk);
        lin.fwd.v = 1'b0;
      end
      begin
        int km, st;
        bsg_manycore_return_packet_s got;
        for (int j = 0; j < 4; j++) begin
          lin.rev.ready_and_rev = 1'b0;
          km = 0;
          while (lout.rev.v !== 1'b1 && km < 200) begin @(negedge clk); km++; end
          got = lout.rev.data;
          st = (j == 0) ? 10 : $urandom_range(0, 5);
          for (int s = 0; s < st; s++) begin
            @(negedge clk);
            checks++;
            if (lout.rev.v !== 1'b1 || lout.rev.data !== got || lout.fwd.ready_and_rev !== 1'b0) begin
              errors++;
              $display("FAIL bp_hold[%0d]: v=%b data=%h fwd_ready=%b required v=1 data=%h fwd_ready=0",
                       j, lout.rev.v, lout.rev.data.data, lout.fwd.ready_and_rev, got.data);
            end
          end
          lin.rev.ready_and_rev = 1'b1;
          hs[j] = cyc;
          checks++;
          if (got !== e[j]) begin
            errors++;
            $display("FAIL bp_resp[%0d]: got data=%h reg=%0d required data=%h reg=%0d",
                     j, got.data, got.reg_id, e[j].data, e[j].reg_id);
          end
          @(negedge clk);
        end
      end
    join
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc[i+1] != hs[i] + 1) begin
        errors++;
        $display("FAIL bp_next_accept[%0d]: got cycle %0d required %0d", i, acc[i+1], hs[i] + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    lin.fwd.v = 1'b1;
    lin.fwd.data = mk(e_remote_load, 2, 4'h0, 32'h0);
    lin.rev.ready_and_rev = 1'b0;
    k = 0;
    while (lout.fwd.ready_and_rev !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    lin.fwd.v = 1'b0;
    k = 0;
    while (lout.rev.v !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (lout.rev.v !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: rev_v=%b required 1", lout.rev.v);
    end
    reset_i = 1'b1;
    err_m = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (lout.rev.v !== 1'b0 || lout.fwd.ready_and_rev !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d]: rev_v=%b fwd_ready=%b err=%b required 0 0 0",
                 i, lout.rev.v, lout.fwd.ready_and_rev, err);
      end
    end
    reset_i = 1'b0;
    lin.rev.ready_and_rev = 1'b1;
    do_txn(mk(e_remote_load, 2, 4'h0, 32'h0), 0, "after_mid_reset");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    lin = '0;
    gx = 7'd3;
    gy = 7'd9;
    reset_i = 1'b1;
    test_reset();
    test_prefill();
    test_store_load();
    test_amo();
    test_err();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_scratch_responder.md
# bsg_manycore_scratch_responder

Manycore endpoint that answers remote requests arriving on a proc link of a `bsg_manycore_hor_io_router_column`, the responder counterpart to the request-issuing BlackParrot tile node. It serves loads, masked stores and word AMOs against a local single-port scratchpad of `els_p` words and returns one reverse packet per forward packet. It sits in the manycore clock domain, one per I/O router row, with no CDC inside.

## Interface
- `addr_width_p`, default `mc_addr_width_gp`: manycore EPA width, in words.
- `data_width_p`, default `mc_data_width_gp` (32): data width.
- `x_cord_width_p`, default `mc_x_cord_width_gp`: X coordinate width.
- `y_cord_width_p`, default `mc_y_cord_width_gp`: Y coordinate width.
- `els_p`, default 1024: scratchpad words. Must be a power of 2.
- `clk_i`, in, 1: manycore clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `link_sif_i`, in, `bsg_manycore_link_sif_width`: fwd request in (valid/data), rev ready-and from router.
- `link_sif_o`, out, same width: fwd ready-and to router, rev response out (valid/data).
- `global_x_i`, in, `x_cord_width_p`: this endpoint's X coordinate.
- `global_y_i`, in, `y_cord_width_p`: this endpoint's Y coordinate.
- `err_o`, out, 1: sticky flag for an out-of-range access or an unsupported op.

## Operation
- FSM states: `e_idle`, `e_access`, `e_amo_wr`, `e_resp`.
- `e_idle`: fwd ready is high. On a fwd handshake, latch the packet and go to `e_access`.
- `e_access`:
  - Remote store: write data under the byte mask from `op_ex`, then go to `e_resp` with `e_return_credit`, data 0.
  - Remote load: read the word, then go to `e_resp` with `e_return_int_wb` and the read data.
  - AMO: read the word, then go to `e_amo_wr`.
- `e_amo_wr`:
  - Write the new value: swap writes payload; add writes old+payload (mod 2^32); or writes old|payload.
  - Go to `e_resp` with `e_return_int_wb`, data = old value.
- `e_resp`: rev valid is held until the rev handshake. Data must stay stable while ready is low. On the handshake, go to `e_idle`.
- Response fields:
  - `reg_id` is copied from the request.
  - `y_cord`/`x_cord` = request `src_y_cord`/`src_x_cord`.
  - Load responses carry `load_info` per the package; byte/half loads are zero- or sign-extended and shifted from the addressed word.
- Index = `addr[lg(els_p)-1:0]`.
  - If `addr >= els_p`, or the op is not in {load, store, amoswap, amoadd, amoor}, set `err_o`.
  - In that case the store/AMO write is suppressed, data is returned as 0, and the response type is kept per op.
- Scratchpad contents are not reset.
- Only one request is in flight at a time. Ordering is strict, so a load after a store to the same address returns the stored value.

## Timing
- Reset values: fwd ready 0, rev valid 0, `err_o` 0, state `e_idle`.
- Fwd ready rises in the cycle after `reset_i` deasserts.
- Fwd handshake at cycle t:
  - Load/store: rev valid at t+2.
  - AMO: rev valid at t+3.
- Next fwd handshake is no earlier than the cycle after the rev handshake.
- Peak throughput is 1 request per 3 cycles for load/store and 1 per 4 for AMO, with rev ready held high.
- Rev backpressure of N cycles delays the next fwd accept by exactly N cycles. No request is dropped.
- Fwd ready is combinational only from state, never from rev ready.
- Reset mid-operation: the in-flight request is discarded, no response is issued, state returns to `e_idle`, and `err_o` clears. A scratchpad write already committed stays.
- `err_o` sets in the `e_access` cycle of the offending request.

## Structure
- Add to `bsg_manycore_pkg`: the state enum `bsg_manycore_scratch_resp_state_e` and the AMO op-to-ALU decode function.
- Use the existing packet/link structs via `declare_bsg_manycore_link_sif_s`.
- One sub-module: `bsg_mem_1rw_sync_mask_write_byte` (els_p × data_width_p) as the scratchpad.
- The load-data extend/shift helper is shared with the vanilla core's `load_packer` logic.

## Test plan
- Store 0xDEADBEEF, full mask, to addr 5, then load addr 5 → credit response with data 0, then `e_return_int_wb` data 0xDEADBEEF; `reg_id` and coordinates echo the source.
- Store mask 4'b0010, data 0x0000AB00, onto 0xDEADBEEF → word becomes 0xDEADABEF. A byte-signed load at byte 2 returns 0xFFFFFFAD.
- amoadd 1 to a word holding 0xFFFFFFFF → response 0xFFFFFFFF, word becomes 0. amoswap 7 → response 0, word becomes 7. amoor 8 → response 7, word becomes 0xF.
- Load with `addr = els_p` → response data 0, `err_o` goes high and stays high. The following valid load still returns correct data.
- Hold rev ready low for 10 cycles with 4 queued loads → each response is held stable. All 4 return in order, with no fwd accepts during stalls.
- Assert `reset_i` while in `e_resp` → rev valid drops the next cycle, no response is emitted, and the next request is served normally.
